// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                  |
// | Purpose  : Round-robin arbiter/sequencer for a shared single-port data   |
// |            SRAM. Requester 0 is the CPU load/store port, requester 1 a   |
// |            secondary master. At most one access per cycle; one owner may |
// |            hold the SRAM for BURST_MAX back-to-back grants while the     |
// |            other waits. Read data returns to the issuer one cycle later. |
// | Ports    : clk, reset (sync, active high)                                |
// |            req/we/addr/wdata 0,1 : requests (held until granted)        |
// |            gnt 0,1               : combinational accept                 |
// |            rvalid/rdata 0,1      : registered read response             |
// |            CEN/WEN/OEN/A/D/Q     : SRAM pins (active-low strobes)       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int AW        = 7,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
);

  localparam int            CW          = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] C_BURST_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_beat_cnt, w_beat_nxt;
  logic          r_last, w_last_nxt;
  logic          r_rd_pend, r_rd_id;
  logic          w_gnt0, w_gnt1;
  logic          w_rd_live;

  // Next-state and grant decision
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the requester that did not go last wins
        if (req0 && (!req1 || r_last)) begin
          w_gnt0      = 1'b1;
          w_state_nxt = OWN0;
          w_beat_nxt  = C_ONE;
        end else if (req1) begin
          w_gnt1      = 1'b1;
          w_state_nxt = OWN1;
          w_beat_nxt  = C_ONE;
        end
      end
      OWN0: begin
        if (req0 && ((r_beat_cnt < C_BURST_MAX) || !req1)) begin
          w_gnt0     = 1'b1;
          w_beat_nxt = (r_beat_cnt == C_BURST_MAX) ? r_beat_cnt : r_beat_cnt + C_ONE;
        end else if (req1) begin
          w_gnt1      = 1'b1;
          w_state_nxt = OWN1;
          w_beat_nxt  = C_ONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (req1 && ((r_beat_cnt < C_BURST_MAX) || !req0)) begin
          w_gnt1     = 1'b1;
          w_beat_nxt = (r_beat_cnt == C_BURST_MAX) ? r_beat_cnt : r_beat_cnt + C_ONE;
        end else if (req0) begin
          w_gnt0      = 1'b1;
          w_state_nxt = OWN0;
          w_beat_nxt  = C_ONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Reset suppresses any grant in the same cycle
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_last_nxt = w_gnt0 ? 1'b0 : (w_gnt1 ? 1'b1 : r_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_last     <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_id    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_last     <= w_last_nxt;
      r_rd_pend  <= (w_gnt0 & ~we0) | (w_gnt1 & ~we1);
      r_rd_id    <= w_gnt1;
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  // SRAM strobes follow the granted requester; idle bus is parked at zero
  assign CEN = ~(w_gnt0 | w_gnt1);
  assign WEN = w_gnt0 ? ~we0   : (w_gnt1 ? ~we1   : 1'b1);
  assign A   = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
  assign D   = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

  // A pending read is dropped if reset arrives in its response cycle
  assign w_rd_live = r_rd_pend & ~reset;
  assign OEN       = ~w_rd_live;
  assign rvalid0   = w_rd_live & ~r_rd_id;
  assign rvalid1   = w_rd_live &  r_rd_id;
  assign rdata0    = rvalid0 ? Q : '0;
  assign rdata1    = rvalid1 ? Q : '0;

endmodule
`default_nettype wire
